// File: rtl/scalar_data_memory.sv
// Scalar data memory for the single-cycle processor.
// The processor read is combinational. A host port uses a req/ack handshake.
// After reset, a clear sweep zeroes every word. Sticky flags record
// misaligned and out-of-range processor accesses.
module scalar_data_memory #(
  parameter int N     = 24,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  address,
  input  logic          MemWrite,
  input  logic [N-1:0]  write_scalar_data,
  output logic [N-1:0]  read_scalar_data,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [N-1:0]  host_wdata,
  output logic          host_ack,
  output logic [N-1:0]  host_rdata,
  output logic          busy,
  output logic          err_align,
  output logic          err_range
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  // Architectural state
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic [N-1:0]  rdata_q, rdata_d;
  logic          err_align_q, err_align_d;
  logic          err_range_q, err_range_d;

  // Storage array. It is never reset; the clear sweep initialises it.
  logic [N-1:0]  mem [DEPTH];

  // Decoded processor access and host acceptance terms
  logic          idle;
  logic [AW-1:0] p_idx;
  logic          p_oor;
  logic          p_mis;
  logic          p_wr;
  logic          host_go;
  logic          host_rd_go;
  logic          host_wr_go;

  // Single shared write port
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [N-1:0]  mem_wdata;

  // Decode the processor address and decide which host request is accepted.
  // A request seen during the ack cycle is ignored, so one request that stays
  // high produces at most one transaction every two cycles.
  always_comb begin
    idle       = (state_q == S_IDLE);
    p_idx      = address[AW+1:2];
    p_oor      = |address[N-1:AW+2];
    p_mis      = |address[1:0];
    p_wr       = idle & MemWrite & ~p_oor;
    host_go    = idle & host_req & ~ack_q;
    host_rd_go = host_go & ~host_we;
    // The processor owns the write port, so a host write waits while MemWrite is high.
    host_wr_go = host_go & host_we & ~MemWrite;
  end

  // Arbitrate the write port: clear sweep, then processor, then host.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (p_wr) begin
      mem_we    = 1'b1;
      mem_waddr = p_idx;
      mem_wdata = write_scalar_data;
    end else if (host_wr_go) begin
      mem_we    = 1'b1;
      mem_waddr = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Processor read. It returns zero during the sweep and for out-of-range addresses.
  always_comb begin
    read_scalar_data = '0;
    if (idle && !p_oor) begin
      read_scalar_data = mem[p_idx];
    end
  end

  // Compute the next state of the FSM, host response and error flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    ack_d       = host_rd_go | host_wr_go;
    rdata_d     = rdata_q;
    err_align_d = err_align_q | (idle & p_mis);
    err_range_d = err_range_q | (idle & p_oor);
    case (state_q)
      S_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (host_rd_go) begin
          rdata_d = mem[host_addr];
        end
      end
      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // FSM and registered outputs. Reset restarts the sweep and drops any pending host request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      err_align_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      err_align_q <= err_align_d;
      err_range_q <= err_range_d;
    end
  end

  // Memory write. Reads in the same cycle see the old contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign host_ack   = ack_q;
  assign host_rdata = rdata_q;
  assign busy       = busy_q;
  assign err_align  = err_align_q;
  assign err_range  = err_range_q;

endmodule

// File: doc/scalar_data_memory.md
Name: scalar_data_memory

Overview:
- Scalar data memory sitting directly downstream of the single-cycle processor.
- Consumes the processor's byte address (alu_scalar_result), MemWrite and write_scalar_data, and returns read_scalar_data combinationally within the same cycle.
- Adds a host load/inspect port with a req/ack handshake, a post-reset clear sweep and sticky access-error flags.
- The processor has priority on the write path; host writes are deferred, never dropped.

Parameters:
- N, 24, data word width in bits.
- DEPTH, 256, number of N-bit words; must be a power of two.
- AW, $clog2(DEPTH), word-index width.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  N  processor byte address; word index = address[AW+1:2].
- MemWrite  in  1  processor write enable.
- write_scalar_data  in  N  processor write data.
- read_scalar_data  out  N  processor read data, combinational.
- host_req  in  1  host request; held high until host_ack.
- host_we  in  1  host write (1) or read (0); sampled while host_req is high.
- host_addr  in  AW  host word index.
- host_wdata  in  N  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  N  registered host read data; valid from the host_ack cycle, held until the next host read.
- busy  out  1  high while the clear sweep runs.
- err_align  out  1  sticky: processor accessed with address[1:0] != 0.
- err_range  out  1  sticky: processor address >= 4*DEPTH.

Behaviour:
- Reset (rst = 0, async): state goes to CLEAR, clear counter to 0, host_ack = 0, host_rdata = 0, err_align = 0, err_range = 0, busy = 1. Reset asserted mid-operation aborts any pending host transaction with no ack; reset asserted mid-sweep restarts the sweep from word 0.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Writes 0 to word[counter] every cycle; counter increments.
  - After writing word DEPTH-1, moves to IDLE. The sweep takes exactly DEPTH cycles after reset release.
  - busy = 1 throughout.
  - read_scalar_data = 0; processor writes are ignored; host_req is not acknowledged.
- IDLE, processor port:
  - read_scalar_data = mem[address[AW+1:2]], combinational.
  - Write when MemWrite = 1: mem[index] <= write_scalar_data at the clock edge.
  - A same-cycle read of the word being written returns the old value.
  - Out of range (address >= 4*DEPTH): read returns 0, write is suppressed, err_range sets.
  - Misaligned (address[1:0] != 0): the access uses address[AW+1:2] (low bits ignored) and err_align sets.
  - Error flags are set only in IDLE, and only when MemWrite = 1 or on any cycle where the address is presented while busy = 0. Both flags clear only on reset.
- IDLE, host port:
  - Read: when host_req = 1 and host_we = 0, host_rdata <= mem[host_addr] and host_ack = 1 in the next cycle. Latency is 1 cycle. If the processor writes the same word in the same cycle, host_rdata gets the old value.
  - Write: when host_req = 1 and host_we = 1 and MemWrite = 0, mem[host_addr] <= host_wdata and host_ack pulses the next cycle.
  - If MemWrite = 1 in that cycle, the host write stalls with no ack and retries every cycle until MemWrite = 0.
- Handshake rules:
  - host_ack is high for exactly 1 cycle per transaction.
  - The host must drop host_req, or present a new request, in the cycle host_ack is high.
  - A request still high in the ack cycle is treated as a new transaction only from the following cycle. This gives at most one transaction per 2 cycles.
  - host_we, host_addr and host_wdata must be stable while host_req is high and no ack has been given.
- host_rdata is unchanged by host writes.

Test Plan:
- Reset release with DEPTH = 256: busy stays 1 for 256 cycles, then 0. A read of address 0x0003FC returns 0, and a read during the sweep returns 0.
- Processor write: MemWrite = 1, address = 0x000010, data = 0xABCDEF. The next cycle a read of 0x000010 returns 0xABCDEF, and the same-cycle read returned the old 0.
- Host write contention: host writes 0x123456 to index 5 while MemWrite = 1 for 3 cycles. host_ack is held off and pulses 1 cycle after MemWrite drops. The processor then reads 0x000014 and gets 0x123456.
- Host read back-to-back: host reads index 4 (0xABCDEF) with host_req held high. host_ack pulses every 2nd cycle, host_rdata = 0xABCDEF, and each pulse is exactly 1 cycle wide.
- Errors:
  - Processor write to 0x000401 with DEPTH = 256: err_range = 1 and no memory word changes.
  - Processor write to 0x000022: err_align = 1 and word 8 is written.
  - Both flags stay set until rst = 0.
- Mid-sweep reset: assert rst = 0 at sweep cycle 100 and with a host request pending. No ack is produced, and the sweep restarts at 0, taking 256 cycles after release.
